// File: rtl/sdram_arbit_if.sv
// Bus bundle between the SDRAM phase arbiter and its requesters / SDRAM pins.
// The arbiter uses the slave modport; the requester side uses master.
interface sdram_arbit_if #(
    parameter int ADDR_W = 12,
    parameter int BANK_W = 2
);
    logic              init_end;
    logic [3:0]        init_cmd;
    logic [ADDR_W-1:0] init_addr;

    logic              aref_req;
    logic              wr_req;
    logic              rd_req;
    logic              aref_end;
    logic              wr_end;
    logic              rd_end;

    logic [3:0]        aref_cmd;
    logic [ADDR_W-1:0] aref_addr;
    logic [3:0]        wr_cmd;
    logic [ADDR_W-1:0] wr_addr;
    logic [BANK_W-1:0] wr_bank;
    logic [3:0]        rd_cmd;
    logic [ADDR_W-1:0] rd_addr;
    logic [BANK_W-1:0] rd_bank;

    logic              aref_en;
    logic              wr_en;
    logic              rd_en;

    logic [3:0]        sdram_cmd;
    logic [ADDR_W-1:0] sdram_addr;
    logic [BANK_W-1:0] sdram_bank;

    modport slave (
        input  init_end, init_cmd, init_addr,
        input  aref_req, wr_req, rd_req,
        input  aref_end, wr_end, rd_end,
        input  aref_cmd, aref_addr,
        input  wr_cmd, wr_addr, wr_bank,
        input  rd_cmd, rd_addr, rd_bank,
        output aref_en, wr_en, rd_en,
        output sdram_cmd, sdram_addr, sdram_bank
    );

    modport master (
        output init_end, init_cmd, init_addr,
        output aref_req, wr_req, rd_req,
        output aref_end, wr_end, rd_end,
        output aref_cmd, aref_addr,
        output wr_cmd, wr_addr, wr_bank,
        output rd_cmd, rd_addr, rd_bank,
        input  aref_en, wr_en, rd_en,
        input  sdram_cmd, sdram_addr, sdram_bank
    );
endinterface

// File: rtl/sdram_arbit.sv
// SDRAM phase arbiter: init pass-through, then refresh/write/read bus ownership.
// Define ARB_RR_EN to alternate write/read grants when both are pending.
module sdram_arbit #(
    parameter logic [3:0] CMD_NOP = 4'b0111,
    parameter int         ADDR_W  = 12,
    parameter int         BANK_W  = 2
) (
    input logic          sclk,
    input logic          s_rst_n,
    sdram_arbit_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARBIT,
        ST_AREF,
        ST_WRITE,
        ST_READ
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic              pick_wr;

`ifdef ARB_RR_EN
    logic last_rd_q, last_rd_d;

    // Write yields only when read is also pending and write won last time.
    always_comb begin
        pick_wr = bus.wr_req && !(bus.rd_req && !last_rd_q);
    end
`else
    always_comb begin
        pick_wr = bus.wr_req;
    end
`endif

    always_comb begin
        state_d = state_q;
        cmd_d   = CMD_NOP;
        addr_d  = '0;
        bank_d  = '0;
`ifdef ARB_RR_EN
        last_rd_d = last_rd_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cmd_d  = bus.init_cmd;
                addr_d = bus.init_addr;
                if (bus.init_end) begin
                    state_d = ST_ARBIT;
                end
            end
            ST_ARBIT: begin
                if (bus.aref_req) begin
                    state_d = ST_AREF;
                end else if (pick_wr) begin
                    state_d = ST_WRITE;
`ifdef ARB_RR_EN
                    last_rd_d = 1'b0;
`endif
                end else if (bus.rd_req) begin
                    state_d = ST_READ;
`ifdef ARB_RR_EN
                    last_rd_d = 1'b1;
`endif
                end
            end
            ST_AREF: begin
                cmd_d  = bus.aref_cmd;
                addr_d = bus.aref_addr;
                if (bus.aref_end) begin
                    state_d = ST_ARBIT;
                end
            end
            ST_WRITE: begin
                cmd_d  = bus.wr_cmd;
                addr_d = bus.wr_addr;
                bank_d = bus.wr_bank;
                if (bus.wr_end) begin
                    state_d = ST_ARBIT;
                end
            end
            ST_READ: begin
                cmd_d  = bus.rd_cmd;
                addr_d = bus.rd_addr;
                bank_d = bus.rd_bank;
                if (bus.rd_end) begin
                    state_d = ST_ARBIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q <= ST_IDLE;
            cmd_q   <= CMD_NOP;
            addr_q  <= '0;
            bank_q  <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            bank_q  <= bank_d;
        end
    end

`ifdef ARB_RR_EN
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            last_rd_q <= 1'b1;
        end else begin
            last_rd_q <= last_rd_d;
        end
    end
`endif

    // Grants decode straight from the state register so reset drops them at once.
    assign bus.aref_en    = (state_q == ST_AREF);
    assign bus.wr_en      = (state_q == ST_WRITE);
    assign bus.rd_en      = (state_q == ST_READ);
    assign bus.sdram_cmd  = cmd_q;
    assign bus.sdram_addr = addr_q;
    assign bus.sdram_bank = bank_q;

endmodule
